// File: rtl/fp16_add_scheduler.sv
// Round-robin front end that shares one fixed-latency, fully pipelined FP16 adder
// among N requesters and routes each result back to the requester that issued it.
module fp16_add_scheduler #(
    parameter int N   = 4,
    parameter int LAT = 4
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [16*N-1:0] req_a,
    input  logic [16*N-1:0] req_b,
    output logic [N-1:0]    req_ready,
    output logic [15:0]     add_a,
    output logic [15:0]     add_b,
    output logic            add_valid,
    input  logic [15:0]     add_result,
    input  logic            add_done,
    output logic [N-1:0]    resp_valid,
    output logic [15:0]     resp_data,
    output logic            busy,
    output logic            err,
    output logic [15:0]     issue_count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_r;
    logic [IW-1:0] gidx_s;
    logic [IW-1:0] next_ptr_s;
    logic [IW:0]   cand_s;
    logic          found_s;
    logic [N-1:0]  grant_s;
    logic          xfer_s;

    logic          add_valid_r;
    logic [15:0]   add_a_r;
    logic [15:0]   add_b_r;
    logic [IW-1:0] issue_idx_r;
    logic          tag_v_r   [LAT];
    logic [IW-1:0] tag_idx_r [LAT];
    logic          pipe_any_s;
    logic [N-1:0]  resp_valid_r;
    logic [15:0]   resp_data_r;
    logic          err_r;
    logic [15:0]   issue_count_r;

    // Round-robin search starting at ptr_r; grant is suppressed while reset is held.
    always_comb begin
        grant_s = '0;
        gidx_s  = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = {1'b0, ptr_r} + (IW+1)'(k);
            if (cand_s >= (IW+1)'(N)) begin
                cand_s = cand_s - (IW+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req_valid[cand_s[IW-1:0]]) begin
                found_s = 1'b1;
                gidx_s  = cand_s[IW-1:0];
            end else begin
                found_s = found_s;
            end
        end
        if (found_s && rst_n) begin
            grant_s[gidx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
        xfer_s = |(req_valid & grant_s);
        if (gidx_s == IW'(N-1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = gidx_s + IW'(1);
        end
    end

    // Busy covers the issue register, every tag stage and the response register.
    always_comb begin
        pipe_any_s = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            pipe_any_s = pipe_any_s | tag_v_r[k];
        end
    end

    // Issue, tag tracking and response routing state.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r         <= '0;
            add_valid_r   <= 1'b0;
            add_a_r       <= 16'h0000;
            add_b_r       <= 16'h0000;
            issue_idx_r   <= '0;
            resp_valid_r  <= '0;
            resp_data_r   <= 16'h0000;
            err_r         <= 1'b0;
            issue_count_r <= 16'h0000;
            for (int k = 0; k < LAT; k++) begin
                tag_v_r[k]   <= 1'b0;
                tag_idx_r[k] <= '0;
            end
        end else begin
            add_valid_r <= xfer_s;
            if (xfer_s) begin
                ptr_r         <= next_ptr_s;
                add_a_r       <= req_a[{gidx_s, 4'b0000} +: 16];
                add_b_r       <= req_b[{gidx_s, 4'b0000} +: 16];
                issue_idx_r   <= gidx_s;
                issue_count_r <= issue_count_r + 16'd1;
            end
            // Stage 0 is filled alongside the adder input so the tail lines up with add_done.
            tag_v_r[0]   <= add_valid_r;
            tag_idx_r[0] <= issue_idx_r;
            for (int k = 1; k < LAT; k++) begin
                tag_v_r[k]   <= tag_v_r[k-1];
                tag_idx_r[k] <= tag_idx_r[k-1];
            end
            resp_valid_r <= '0;
            if (add_done && tag_v_r[LAT-1]) begin
                resp_valid_r[tag_idx_r[LAT-1]] <= 1'b1;
                resp_data_r                    <= add_result;
            end
            if (add_done != tag_v_r[LAT-1]) begin
                err_r <= 1'b1;
            end
        end
    end

    assign req_ready   = grant_s;
    assign add_valid   = add_valid_r;
    assign add_a       = add_a_r;
    assign add_b       = add_b_r;
    assign resp_valid  = resp_valid_r;
    assign resp_data   = resp_data_r;
    assign err         = err_r;
    assign issue_count = issue_count_r;
    assign busy        = add_valid_r | pipe_any_s | (|resp_valid_r);

endmodule

// File: tb/tb_fp16_add_scheduler.sv
// Directed self-checking bench for fp16_add_scheduler with a behavioural
// LAT-cycle adder whose results are fixed by hand-chosen operand pairs.
module tb_fp16_add_scheduler;

    localparam int N   = 4;
    localparam int LAT = 4;

    logic            clk_in = 1'b0;
    logic            rst_n  = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [16*N-1:0] req_a = '0;
    logic [16*N-1:0] req_b = '0;
    logic [N-1:0]    req_ready;
    logic [15:0]     add_a, add_b;
    logic            add_valid;
    logic [15:0]     add_result;
    logic            add_done;
    logic [N-1:0]    resp_valid;
    logic [15:0]     resp_data;
    logic            busy, err;
    logic [15:0]     issue_count;
    logic            inject = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [15:0] a_tab [N];
    logic [15:0] b_tab [N];

    fp16_add_scheduler #(.N(N), .LAT(LAT)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
        .add_result(add_result), .add_done(add_done), .resp_valid(resp_valid),
        .resp_data(resp_data), .busy(busy), .err(err), .issue_count(issue_count)
    );

    always #5 clk_in = ~clk_in;

    // Adder results for the operand pairs this bench uses (1.0+2.0=3.0, 2.0+(-2.0)=0, etc.).
    function automatic logic [15:0] fp_sum(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h3C00 && b == 16'h4000) return 16'h4200;
        if (a == 16'h4000 && b == 16'hC000) return 16'h0000;
        if (a == 16'h3C00 && b == 16'h3C00) return 16'h4000;
        if (a == 16'h4200 && b == 16'h3C00) return 16'h4400;
        if (a == 16'h4400 && b == 16'h4400) return 16'h4800;
        return 16'hFFFF;
    endfunction

    logic        m_v [LAT];
    logic [15:0] m_a [LAT];
    logic [15:0] m_b [LAT];

    // Behavioural shared adder, reset together with the scheduler.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                m_v[k] <= 1'b0; m_a[k] <= 16'h0000; m_b[k] <= 16'h0000;
            end
        end else begin
            m_v[0] <= add_valid; m_a[0] <= add_a; m_b[0] <= add_b;
            for (int k = 1; k < LAT; k++) begin
                m_v[k] <= m_v[k-1]; m_a[k] <= m_a[k-1]; m_b[k] <= m_b[k-1];
            end
        end
    end
    assign add_done   = m_v[LAT-1] | inject;
    assign add_result = fp_sum(m_a[LAT-1], m_b[LAT-1]);

    task automatic load_ops();
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = a_tab[i];
            req_b[16*i +: 16] = b_tab[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        req_valid = 4'b1111;
        load_ops();
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        @(negedge clk_in);
        tests++;
        if ({add_valid, resp_valid, busy, err} !== 7'b0) begin
            fails++; $display("FAIL reset_flags got av=%b rv=%b busy=%b err=%b want 0", add_valid, resp_valid, busy, err);
        end
        tests++;
        if ({add_a, add_b, resp_data, issue_count} !== 64'h0) begin
            fails++; $display("FAIL reset_data got %h %h %h %h want 0", add_a, add_b, resp_data, issue_count);
        end
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        @(negedge clk_in);
        req_valid = 4'b0001;
        req_a[15:0] = 16'h3C00;
        req_b[15:0] = 16'h4000;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready got %b want 0001", req_ready); end
        for (int t = 1; t <= LAT + 3; t++) begin
            @(negedge clk_in);
            req_valid = '0;
            if (t == 1) begin
                tests++;
                if (add_valid !== 1'b1 || add_a !== 16'h3C00 || add_b !== 16'h4000) begin
                    fails++; $display("FAIL single_issue got av=%b a=%h b=%h want 1 3c00 4000", add_valid, add_a, add_b);
                end
            end
            if (t == LAT + 2) begin
                tests++;
                if (resp_valid !== 4'b0001 || resp_data !== 16'h4200) begin
                    fails++; $display("FAIL single_resp got rv=%b d=%h want 0001 4200", resp_valid, resp_data);
                end
            end else begin
                tests++;
                if (resp_valid !== 4'b0000) begin fails++; $display("FAIL single_quiet t=%0d got rv=%b want 0000", t, resp_valid); end
            end
            tests++;
            if (busy !== (t <= LAT + 2)) begin fails++; $display("FAIL single_busy t=%0d got %b want %b", t, busy, (t <= LAT + 2)); end
        end
        tests++;
        if (issue_count !== 16'd1) begin fails++; $display("FAIL single_count got %0d want 1", issue_count); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_rv;
        logic [15:0]  exp_d;
        int k;
        load_ops();
        for (int t = 0; t < 16; t++) begin
            @(negedge clk_in);
            req_valid = (t < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (t < 8) begin
                tests++;
                if (req_ready !== (4'b0001 << (t % 4))) begin
                    fails++; $display("FAIL fair_grant t=%0d got %b want %b", t, req_ready, 4'b0001 << (t % 4));
                end
            end
            k = t - (LAT + 2);
            exp_rv = (k >= 0 && k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
            exp_d  = (k >= 0 && k < 8) ? fp_sum(a_tab[k % 4], b_tab[k % 4]) : 16'h0000;
            tests++;
            if (resp_valid !== exp_rv || (exp_rv != 4'b0000 && resp_data !== exp_d)) begin
                fails++; $display("FAIL fair_resp t=%0d got rv=%b d=%h want %b %h", t, resp_valid, resp_data, exp_rv, exp_d);
            end
        end
        tests++;
        if (issue_count !== 16'd8) begin fails++; $display("FAIL fair_count got %0d want 8", issue_count); end
    endtask

    task automatic test_ptr_skip();
        @(negedge clk_in);
        req_valid = 4'b0010;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin fails++; $display("FAIL skip_first got %b want 0010", req_ready); end
        @(negedge clk_in);
        req_valid = 4'b0011;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin fails++; $display("FAIL skip_wrap got %b want 0001", req_ready); end
        @(negedge clk_in);
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin fails++; $display("FAIL skip_after got %b want 0010", req_ready); end
        @(negedge clk_in);
        req_valid = '0;
        repeat (LAT + 4) @(negedge clk_in);
        tests++;
        if (err !== 1'b0 || busy !== 1'b0 || issue_count !== 16'd11) begin
            fails++; $display("FAIL skip_drain got err=%b busy=%b cnt=%0d want 0 0 11", err, busy, issue_count);
        end
    endtask

    task automatic test_protocol_error();
        @(negedge clk_in);
        inject = 1'b1;
        @(negedge clk_in);
        inject = 1'b0;
        tests++;
        if (err !== 1'b1 || resp_valid !== 4'b0000) begin
            fails++; $display("FAIL perr_set got err=%b rv=%b want 1 0000", err, resp_valid);
        end
        repeat (4) @(negedge clk_in);
        tests++;
        if (err !== 1'b1) begin fails++; $display("FAIL perr_sticky got %b want 1", err); end
        do_reset();
        #1;
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL perr_clear got %b want 0", err); end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        load_ops();
        for (int t = 0; t < 3; t++) begin
            @(negedge clk_in);
            req_valid = 4'b0111;
            #1;
            tests++;
            if (req_ready !== (4'b0001 << t)) begin fails++; $display("FAIL mid_grant t=%0d got %b want %b", t, req_ready, 4'b0001 << t); end
        end
        @(negedge clk_in);
        req_valid = '0;
        @(negedge clk_in);
        rst_n = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk_in);
            if (resp_valid !== 4'b0000 || busy !== 1'b0) seen++;
        end
        tests++;
        if (seen != 0) begin fails++; $display("FAIL mid_flush got %0d active cycles want 0", seen); end
        tests++;
        if (issue_count !== 16'd0) begin fails++; $display("FAIL mid_count got %0d want 0", issue_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        req_a[15:0] = 16'h3C00;
        req_b[15:0] = 16'h3C00;
        @(negedge clk_in);
        req_valid = 4'b0001;
        repeat (65535) @(negedge clk_in);
        tests++;
        if (issue_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_full got %h want ffff", issue_count); end
        @(negedge clk_in);
        req_valid = '0;
        tests++;
        if (issue_count !== 16'h0000) begin fails++; $display("FAIL wrap_zero got %h want 0000", issue_count); end
        repeat (LAT + 4) @(negedge clk_in);
        tests++;
        if (err !== 1'b0 || busy !== 1'b0 || issue_count !== 16'h0000) begin
            fails++; $display("FAIL wrap_side got err=%b busy=%b cnt=%h want 0 0 0000", err, busy, issue_count);
        end
    endtask

    initial begin
        a_tab[0] = 16'h3C00; b_tab[0] = 16'h4000;
        a_tab[1] = 16'h4000; b_tab[1] = 16'hC000;
        a_tab[2] = 16'h3C00; b_tab[2] = 16'h3C00;
        a_tab[3] = 16'h4200; b_tab[3] = 16'h3C00;
        test_reset();
        test_single_op();
        do_reset();
        test_fairness();
        test_ptr_skip();
        test_protocol_error();
        test_reset_midflight();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
